tcp_tx_buf: RTL and testbench

//  Consumer (in_tx end) of tcp_data_ifc on the transmit path. Takes user bytes,

---
 rtl/tcp_tx_pkg.sv | 21 ++
 rtl/tcp_tx_buf_if.sv | 33 +++
 rtl/tcp_tx_fifo.sv | 73 +++++++
 rtl/tcp_tx_buf.sv | 136 +++++++++++++
 tb/tb_tcp_tx_buf.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_tx_pkg.sv
// Shared types and defaults for the TCP transmit buffer.
//   tx_state_e : buffer FSM states
//   byte_t     : payload byte
//   TCP_*      : default sizing, also used by the TX packet builder
package tcp_tx_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        REQ  = 2'd2,
        SEND = 2'd3
    } tx_state_e;

    localparam int TCP_DEPTH      = 2048;
    localparam int TCP_MSS        = 1460;
    localparam int TCP_WAIT_TICKS = 1000;
    localparam int SEG_LEN_W      = 11;

endpackage

// File: rtl/tcp_tx_buf_if.sv
// Interfaces around the TCP transmit buffer.
//   tcp_data_ifc : user byte stream (dat/val/snd in, cts back to the user)
//                  master = user, slave = buffer
//   tcp_seg_ifc  : segment request + payload stream towards the packet builder
//                  master = buffer, slave = builder
interface tcp_data_ifc;
    import tcp_tx_pkg::*;

    byte_t dat;
    logic  val;
    logic  snd;
    logic  cts;

    modport master (output dat, val, snd, input cts);
    modport slave  (input dat, val, snd, output cts);
endinterface

interface tcp_seg_ifc;
    import tcp_tx_pkg::*;

    logic                 seg_req;
    logic [SEG_LEN_W-1:0] seg_len;
    logic                 seg_ack;
    byte_t                out_dat;
    logic                 out_val;
    logic                 out_last;
    logic                 out_rdy;

    modport master (output seg_req, seg_len, out_dat, out_val, out_last,
                    input  seg_ack, out_rdy);
    modport slave  (input  seg_req, seg_len, out_dat, out_val, out_last,
                    output seg_ack, out_rdy);
endinterface

// File: rtl/tcp_tx_fifo.sv
// Synchronous show-ahead byte FIFO (DEPTH x 8).
//   clk, rst_n   : clock, async active-low reset (pointers/count only)
//   i_wr, i_wdat : write strobe and data (ignored when full)
//   i_rd         : pop strobe (ignored when empty)
//   o_rdat       : head byte, valid whenever not empty
//   o_count      : current occupancy
//   o_count_nxt  : occupancy after this cycle's write/pop
//   o_full, o_empty
module tcp_tx_fifo
    import tcp_tx_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr,
    input  byte_t       i_wdat,
    input  logic        i_rd,
    output byte_t       o_rdat,
    output logic [AW:0] o_count,
    output logic [AW:0] o_count_nxt,
    output logic        o_full,
    output logic        o_empty
);

    localparam int CW = AW + 1;

    byte_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           w_wr;
    logic           w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr    = i_wr & ~o_full;
    assign w_rd    = i_rd & ~o_empty;

    // Show-ahead: the head byte is presented combinationally from the read pointer.
    assign o_rdat  = r_mem[r_rptr];
    assign o_count = r_count;

    always_comb begin
        o_count_nxt = r_count;
        if (w_wr && !w_rd)
            o_count_nxt = r_count + CW'(1);
        else if (!w_wr && w_rd)
            o_count_nxt = r_count - CW'(1);
    end

    // Storage is not reset; discarding data is done by clearing the pointers.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= i_wdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + AW'(1);
            if (w_rd)
                r_rptr <= r_rptr + AW'(1);
            r_count <= o_count_nxt;
        end
    end

endmodule

// File: rtl/tcp_tx_buf.sv
// TCP transmit buffer: collects user bytes and releases them as payload
// segments on MSS fill, user force-send, or age timeout.
//   clk, rst_n : clock, async active-low reset
//   dif        : user side (dat/val/snd in, cts out)
//   sif        : builder side (seg_req/seg_len, payload stream out; seg_ack/out_rdy in)
//   ovf        : single-cycle pulse when a presented byte is dropped (buffer full)
module tcp_tx_buf
    import tcp_tx_pkg::*;
#(
    parameter int DEPTH      = TCP_DEPTH,
    parameter int MSS        = TCP_MSS,
    parameter int WAIT_TICKS = TCP_WAIT_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    tcp_data_ifc.slave dif,
    tcp_seg_ifc.master sif,
    output logic       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(WAIT_TICKS) + 1;

    localparam logic [CW-1:0] MSS_C   = CW'(MSS);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_C   = TW'(WAIT_TICKS - 1);

    tx_state_e            r_state;
    tx_state_e            w_state_nxt;
    logic [TW-1:0]        r_timer;
    logic [SEG_LEN_W-1:0] r_seg_len;
    logic [SEG_LEN_W-1:0] r_remain;
    logic                 r_snd_pend;
    logic                 r_cts;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_last_pop;
    logic                 w_snd_set;
    logic                 w_fill_go;
    logic [CW-1:0]        w_count;
    logic [CW-1:0]        w_count_nxt;
    logic [SEG_LEN_W-1:0] w_seg_len_nxt;
    byte_t                w_rdat;

    tcp_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr        (w_wr),
        .i_wdat      (dif.dat),
        .i_rd        (w_rd),
        .o_rdat      (w_rdat),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign w_wr       = dif.val & ~w_full;
    assign ovf        = dif.val & w_full;
    assign w_rd       = (r_state == SEND) & sif.out_rdy & ~w_empty;
    assign w_last_pop = w_rd & (r_remain == SEG_LEN_W'(1));

    // A byte arriving together with snd counts as buffered data.
    assign w_snd_set  = dif.snd & ((w_count != '0) | dif.val);

    assign w_fill_go  = (w_count >= MSS_C) | r_snd_pend | (r_timer == TMO_C);

    assign w_seg_len_nxt = (w_count >= MSS_C) ? SEG_LEN_W'(MSS) : SEG_LEN_W'(w_count);

    assign dif.cts      = r_cts;
    assign sif.seg_req  = (r_state == REQ);
    assign sif.seg_len  = r_seg_len;
    assign sif.out_val  = (r_state == SEND);
    assign sif.out_last = (r_state == SEND) & (r_remain == SEG_LEN_W'(1));
    // Gated so the output reads 0 outside a segment (storage itself is unreset).
    assign sif.out_dat  = (r_state == SEND) ? w_rdat : '0;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_wr)         w_state_nxt = FILL;
            FILL: if (w_fill_go)    w_state_nxt = REQ;
            REQ:  if (sif.seg_ack)  w_state_nxt = SEND;
            SEND: if (w_last_pop)   w_state_nxt = (w_count_nxt != '0) ? FILL : IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer    <= '0;
            r_seg_len  <= '0;
            r_remain   <= '0;
            r_snd_pend <= 1'b0;
            r_cts      <= 1'b0;
        end else begin
            // Two free slots keep room for the byte the user may still send
            // in the cycle it sees cts drop.
            r_cts <= (DEPTH_C - w_count_nxt) >= CW'(2);

            // Age of the oldest unsent byte; only measured while filling.
            if ((r_state == IDLE && w_wr) ||
                (r_state == SEND && w_last_pop && w_count_nxt != '0))
                r_timer <= '0;
            else if (r_state == FILL)
                r_timer <= r_timer + TW'(1);

            // A snd arriving on the FILL->REQ edge is kept for the next segment.
            if (r_state == FILL && w_state_nxt == REQ) begin
                r_seg_len  <= w_seg_len_nxt;
                r_snd_pend <= w_snd_set;
            end else if (w_state_nxt == IDLE) begin
                r_snd_pend <= 1'b0;
            end else if (w_snd_set) begin
                r_snd_pend <= 1'b1;
            end

            if (r_state == REQ && sif.seg_ack)
                r_remain <= r_seg_len;
            else if (w_rd)
                r_remain <= r_remain - SEG_LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_tcp_tx_buf.sv
// Scoreboard bench for tcp_tx_buf. Stimulus pushes expected bytes and
// segment lengths into queues; a sink/monitor process acknowledges segments,
// drives out_rdy and checks every transferred byte and every accepted segment.
// A second small instance with a 16-tick age limit covers the timeout path.
module tb_tcp_tx_buf;
    import tcp_tx_pkg::*;

    localparam int DEPTH  = 2048;
    localparam int MSS    = 1460;
    localparam int WAIT   = 1600;
    localparam int T_DEPTH = 64;
    localparam int T_MSS   = 32;
    localparam int T_WAIT  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ovf;
    logic ovf_t;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: never ready, 2: toggle
    int   rem = 0;

    byte_t exp_q[$];
    int    len_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tcp_data_ifc dif();
    tcp_seg_ifc  sif();
    tcp_data_ifc dif_t();
    tcp_seg_ifc  sif_t();

    tcp_tx_buf #(.DEPTH(DEPTH), .MSS(MSS), .WAIT_TICKS(WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .dif(dif), .sif(sif), .ovf(ovf)
    );

    tcp_tx_buf #(.DEPTH(T_DEPTH), .MSS(T_MSS), .WAIT_TICKS(T_WAIT)) dut_t (
        .clk(clk), .rst_n(rst_n), .dif(dif_t), .sif(sif_t), .ovf(ovf_t)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic put(input byte_t d, input logic snd);
        @(negedge clk);
        dif.val = 1'b1;
        dif.dat = d;
        dif.snd = snd;
        exp_q.push_back(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dif.val = 1'b0;
            dif.snd = 1'b0;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || sif.seg_req || sif.out_val)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size() + len_q.size(), 0);
    endtask

    // Sink + monitor: decisions for the coming edge are made here, then the
    // handshakes that edge will complete are checked against the queues.
    initial begin
        int    e_len;
        byte_t e_dat;
        sif.seg_ack = 1'b0;
        sif.out_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sif.seg_ack = 1'b0;
                exp_q.delete();
                len_q.delete();
                rem = 0;
            end else begin
                sif.seg_ack = sif.seg_req;
                case (rdy_mode)
                    0:       sif.out_rdy = 1'b1;
                    1:       sif.out_rdy = 1'b0;
                    default: sif.out_rdy = ~sif.out_rdy;
                endcase
                if (sif.seg_req && sif.seg_ack) begin
                    if (len_q.size() == 0) begin
                        chk("seg_unexpected_len", sif.seg_len, 0);
                    end else begin
                        e_len = len_q.pop_front();
                        chk("seg_len", sif.seg_len, e_len);
                        rem = e_len;
                    end
                end
                if (sif.out_val && sif.out_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("byte_extra", exp_q.size(), 1);
                    end else begin
                        e_dat = exp_q.pop_front();
                        chk("out_dat", sif.out_dat, e_dat);
                        chk("out_last", sif.out_last, (rem == 1));
                        rem--;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s;
        int w0;
        int seen;

        dif.val = 1'b0; dif.snd = 1'b0; dif.dat = '0;
        dif_t.val = 1'b0; dif_t.snd = 1'b0; dif_t.dat = '0;
        sif_t.seg_ack = 1'b0; sif_t.out_rdy = 1'b1;

        // Reset state
        #12;
        chk("rst_cts", dif.cts, 0);
        chk("rst_seg_req", sif.seg_req, 0);
        chk("rst_out_val", sif.out_val, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cts_rise", dif.cts, 1);

        // T1: full-MSS segment, bytes 0..0xB3 wrapping
        rdy_mode = 0;
        len_q.push_back(MSS);
        for (int i = 0; i < MSS; i++) put(byte_t'(i), 1'b0);
        idle(1);
        drain("t1_drain", 4000);

        // T2: force-send of 5 bytes, then snd on an empty buffer
        len_q.push_back(5);
        for (int i = 0; i < 5; i++) put(byte_t'(8'hC0 + i), 1'b0);
        @(negedge clk);
        dif.val = 1'b0; dif.snd = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        dif.snd = 1'b0;
        n = 0;
        while (!sif.seg_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t2_snd_latency_ok", (sif.seg_req && (cyc - s) <= 2), 1);
        drain("t2_drain", 200);
        idle(3);
        @(negedge clk); dif.snd = 1'b1;
        @(negedge clk); dif.snd = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (sif.seg_req) seen = 1;
        end
        chk("t2_empty_snd_no_req", seen, 0);

        // T3: age timeout on the small instance
        chk("t3_cts", dif_t.cts, 1);
        @(negedge clk); dif_t.val = 1'b1; dif_t.dat = 8'hA1; w0 = cyc + 1;
        @(negedge clk); dif_t.dat = 8'hA2;
        @(negedge clk); dif_t.dat = 8'hA3;
        @(negedge clk); dif_t.val = 1'b0;
        n = 0;
        while (!sif_t.seg_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t3_timeout_latency", cyc - w0, T_WAIT);
        chk("t3_seg_len", sif_t.seg_len, 3);
        chk("t3_ovf", ovf_t, 0);
        sif_t.seg_ack = 1'b1;
        @(negedge clk); sif_t.seg_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_out_val", sif_t.out_val, 1);
            chk("t3_out_dat", sif_t.out_dat, 8'hA1 + k);
            chk("t3_out_last", sif_t.out_last, (k == 2));
            @(negedge clk);
        end
        chk("t3_done", sif_t.out_val, 0);

        // T4: backpressure until full; grace byte accepted, next one dropped
        rdy_mode = 1;
        idle(2);
        len_q.push_back(MSS);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            @(negedge clk);
            dif.val = 1'b1;
            dif.snd = 1'b0;
            dif.dat = byte_t'(i) ^ 8'h5A;
            if (i <= DEPTH) exp_q.push_back(dif.dat);
            #1;
            if (i == DEPTH - 1) chk("t4_cts_before", dif.cts, 1);
            if (i == DEPTH) begin
                chk("t4_cts_grace", dif.cts, 0);
                chk("t4_ovf_grace", ovf, 0);
            end
            if (i == DEPTH + 1) chk("t4_ovf_drop", ovf, 1);
        end
        @(negedge clk);
        dif.val = 1'b0;
        #1;
        chk("t4_ovf_pulse_end", ovf, 0);
        chk("t4_count_full", dut.w_count, DEPTH);
        len_q.push_back(DEPTH - MSS);
        @(negedge clk); dif.snd = 1'b1;
        @(negedge clk); dif.snd = 1'b0;
        rdy_mode = 0;
        drain("t4_drain", 6000);

        // T5: toggling ready while writing a follow-on batch
        rdy_mode = 2;
        len_q.push_back(100);
        len_q.push_back(50);
        for (int i = 0; i < 100; i++) put(byte_t'(3 * i + 7), (i == 99));
        for (int i = 0; i < 50; i++) put(byte_t'(8'hE0 ^ i), 1'b0);
        idle(1);
        drain("t5_drain", 6000);

        // T6: reset in the middle of a segment
        rdy_mode = 0;
        idle(2);
        len_q.push_back(20);
        for (int i = 0; i < 20; i++) put(byte_t'(8'h90 + i), (i == 19));
        idle(1);
        n = 0;
        while (!sif.out_val && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_cts", dif.cts, 0);
        chk("t6_seg_req", sif.seg_req, 0);
        chk("t6_seg_len", sif.seg_len, 0);
        chk("t6_out_val", sif.out_val, 0);
        chk("t6_out_last", sif.out_last, 0);
        chk("t6_out_dat", sif.out_dat, 0);
        chk("t6_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_cts_held", dif.cts, 0);
        @(posedge clk); #1;
        chk("t6_cts_rise", dif.cts, 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (sif.seg_req || sif.out_val) seen = 1;
        end
        chk("t6_no_stale_seg", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
